// File: rtl/wb_trace_buffer_if.sv
// rtl/wb_trace_buffer_if.sv - write-back stage observation bus sampled by the trace buffer
interface wb_trace_buffer_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
);
  logic              wb_valid;
  logic              stall_memwb;
  logic [PC_W-1:0]   pc_wb;
  logic [4:0]        rw_wb;
  logic              reg_we_wb;
  logic [DATA_W-1:0] reg_din_wb;
  logic              is_exception;

  modport master (
    output wb_valid, stall_memwb, pc_wb, rw_wb, reg_we_wb, reg_din_wb, is_exception
  );

  modport slave (
    input  wb_valid, stall_memwb, pc_wb, rw_wb, reg_we_wb, reg_din_wb, is_exception
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - circular trace of retired WB events frozen around a PC/exception trigger
module wb_trace_buffer #(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int PC_W       = 32,
  parameter int DATA_W     = 32,
  parameter int POST_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  wb_trace_buffer_if.slave         wb,
  input  logic                     arm,
  input  logic                     trig_pc_en,
  input  logic [PC_W-1:0]          trig_pc,
  input  logic                     trig_exc_en,
  input  logic                     rd_en,
  input  logic [AW-1:0]            rd_idx,
  output logic                     rd_valid,
  output logic                     rd_err,
  output logic [PC_W+DATA_W+6:0]   rd_rec,
  output logic [AW:0]              count,
  output logic [AW-1:0]            trig_pos,
  output logic [1:0]               state
);

  if (POST_DEPTH >= DEPTH || DEPTH < 4 || (1 << AW) != DEPTH) begin : g_bad_params
    $error("wb_trace_buffer: need DEPTH=2**AW >= 4 and POST_DEPTH < DEPTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int REC_W = PC_W + DATA_W + 7;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic [AW-1:0]    post_cnt_q, post_cnt_d;
  logic [AW-1:0]    trig_ptr_q, trig_ptr_d;
  logic             wr_en;
  logic             clear;
  logic             cap;
  logic             trig;
  logic [AW-1:0]    oldest_ptr;
  logic [AW-1:0]    rd_addr;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] mem [DEPTH];

  assign cap = wb.wb_valid & ~wb.stall_memwb & (state_q == ST_ARMED || state_q == ST_POST);
  assign trig = cap & ((trig_pc_en & (wb.pc_wb == trig_pc)) | (trig_exc_en & wb.is_exception));
  assign rec_in = {wb.is_exception, wb.reg_we_wb, wb.rw_wb, wb.reg_din_wb, wb.pc_wb};

  // With count == DEPTH the low bits of count are zero, so the oldest record sits at wr_ptr.
  assign oldest_ptr = wr_ptr_q - count_q[AW-1:0];
  assign trig_pos   = trig_ptr_q - oldest_ptr;
  assign rd_addr    = oldest_ptr + rd_idx;
  assign count      = count_q;
  assign state      = state_q;

  always_comb begin
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    trig_ptr_d = trig_ptr_q;
    wr_en      = 1'b0;
    clear      = 1'b0;
    if (arm) begin
      state_d    = ST_ARMED;
      post_cnt_d = '0;
      clear      = 1'b1;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (cap) begin
            wr_en = 1'b1;
            if (trig) begin
              trig_ptr_d = wr_ptr_q;
              if (POST_DEPTH == 0) begin
                state_d = ST_DONE;
              end else begin
                post_cnt_d = AW'(POST_DEPTH);
                state_d    = ST_POST;
              end
            end
          end
        end
        ST_POST: begin
          if (cap) begin
            wr_en      = 1'b1;
            post_cnt_d = post_cnt_q - AW'(1);
            if (post_cnt_q == AW'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      trig_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      post_cnt_q <= post_cnt_d;
      trig_ptr_q <= trig_ptr_d;
      if (clear) begin
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (count_q != (AW+1)'(DEPTH)) begin
          count_q <= count_q + (AW+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= rec_in;
    end
  end

  // Readout only returns data once the window is frozen; arm swallows a coincident request.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_rec   <= '0;
    end else if (rd_en && !arm) begin
      rd_valid <= 1'b1;
      if (state_q == ST_DONE && {1'b0, rd_idx} < count_q) begin
        rd_rec <= mem[rd_addr];
        rd_err <= 1'b0;
      end else begin
        rd_rec <= '0;
        rd_err <= 1'b1;
      end
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - directed self-checking bench for wb_trace_buffer
module tb_wb_trace_buffer;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int PC_W = 32;
  localparam int DATA_W = 32;
  localparam int POST_DEPTH = 3;
  localparam int REC_W = PC_W + DATA_W + 7;

  logic             clk = 1'b0;
  logic             resetn;
  logic             arm;
  logic             trig_pc_en;
  logic [PC_W-1:0]  trig_pc;
  logic             trig_exc_en;
  logic             rd_en;
  logic [AW-1:0]    rd_idx;
  logic             rd_valid;
  logic             rd_err;
  logic [REC_W-1:0] rd_rec;
  logic [AW:0]      count;
  logic [AW-1:0]    trig_pos;
  logic [1:0]       state;

  int checks = 0;
  int failures = 0;

  wb_trace_buffer_if #(.PC_W(PC_W), .DATA_W(DATA_W)) wb_bus ();

  wb_trace_buffer #(
    .DEPTH(DEPTH), .AW(AW), .PC_W(PC_W), .DATA_W(DATA_W), .POST_DEPTH(POST_DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn), .wb(wb_bus.slave), .arm(arm),
    .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .trig_exc_en(trig_exc_en),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_err(rd_err),
    .rd_rec(rd_rec), .count(count), .trig_pos(trig_pos), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] mk_rec(input logic exc, input logic we, input logic [4:0] rw,
                                              input logic [DATA_W-1:0] din, input logic [PC_W-1:0] pc);
    return {exc, we, rw, din, pc};
  endfunction

  task automatic retire(input logic [PC_W-1:0] pc, input logic [4:0] rw, input logic we,
                        input logic [DATA_W-1:0] din, input logic exc);
    wb_bus.wb_valid     = 1'b1;
    wb_bus.pc_wb        = pc;
    wb_bus.rw_wb        = rw;
    wb_bus.reg_we_wb    = we;
    wb_bus.reg_din_wb   = din;
    wb_bus.is_exception = exc;
    tick();
    wb_bus.wb_valid     = 1'b0;
    wb_bus.is_exception = 1'b0;
  endtask

  task automatic read(input logic [AW-1:0] idx);
    rd_en  = 1'b1;
    rd_idx = idx;
    tick();
    rd_en  = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; arm = 1'b0; trig_pc_en = 1'b0; trig_pc = '0; trig_exc_en = 1'b0;
    rd_en = 1'b0; rd_idx = '0;
    wb_bus.wb_valid = 1'b0; wb_bus.stall_memwb = 1'b0; wb_bus.pc_wb = '0; wb_bus.rw_wb = '0;
    wb_bus.reg_we_wb = 1'b0; wb_bus.reg_din_wb = '0; wb_bus.is_exception = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    check("reset_state", state, 0);
    check("reset_count", count, 0);
    check("reset_trig_pos", trig_pos, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_err", rd_err, 0);
    check("reset_rd_rec", rd_rec, 0);

    for (int k = 0; k < 10; k++) retire(32'h40 + 32'(4 * k), 5'd1, 1'b1, 32'(k), 1'b0);
    check("idle_state", state, 0);
    check("idle_count", count, 0);
    read(3'd0);
    check("idle_rd_valid", rd_valid, 1);
    check("idle_rd_err", rd_err, 1);
    check("idle_rd_rec", rd_rec, 0);
    tick();
    check("idle_rd_valid_drop", rd_valid, 0);

    // Basic window: trigger at the 5th retire, three post records.
    trig_pc_en = 1'b1; trig_pc = 32'hBFC00010;
    do_arm();
    check("basic_armed", state, 1);
    check("basic_count0", count, 0);
    for (int k = 0; k < 8; k++) begin
      retire(32'hBFC00000 + 32'(4 * k), 5'(k), 1'b1, 32'hBFC00000 + 32'(4 * k), 1'b0);
      if (k == 4) check("basic_post_entered", state, 2);
    end
    check("basic_done", state, 3);
    check("basic_count", count, 8);
    check("basic_trig_pos", trig_pos, 4);
    retire(32'hBFC00020, 5'd8, 1'b1, 32'h0, 1'b0);
    check("basic_frozen_count", count, 8);
    read(3'd0);
    check("basic_rd0_valid", rd_valid, 1);
    check("basic_rd0_pc", rd_rec[PC_W-1:0], 32'hBFC00000);
    read(3'd4);
    check("basic_rd4_rec", rd_rec, mk_rec(1'b0, 1'b1, 5'd4, 32'hBFC00010, 32'hBFC00010));
    read(3'd7);
    check("basic_rd7_pc", rd_rec[PC_W-1:0], 32'hBFC0001C);
    check("basic_rd7_err", rd_err, 0);

    // Wrap: 19 captures into 8 slots, trigger record k=15 survives.
    trig_pc = 32'h13C;
    do_arm();
    for (int k = 0; k < 20; k++) retire(32'h100 + 32'(4 * k), 5'(k), k[0], 32'(k), 1'b0);
    check("wrap_done", state, 3);
    check("wrap_count", count, 8);
    check("wrap_trig_pos", trig_pos, 4);
    read(3'd0);
    check("wrap_rd0_pc", rd_rec[PC_W-1:0], 32'h12C);
    read(3'd4);
    check("wrap_rd4_rec", rd_rec, mk_rec(1'b0, 1'b1, 5'd15, 32'd15, 32'h13C));
    read(3'd7);
    check("wrap_rd7_pc", rd_rec[PC_W-1:0], 32'h148);

    // Stall and exception trigger.
    trig_pc_en = 1'b0; trig_exc_en = 1'b1;
    do_arm();
    retire(32'h200, 5'd2, 1'b1, 32'hAA, 1'b0);
    wb_bus.stall_memwb = 1'b1;
    retire(32'h204, 5'd3, 1'b1, 32'hBB, 1'b1);
    retire(32'h204, 5'd3, 1'b1, 32'hBB, 1'b0);
    wb_bus.stall_memwb = 1'b0;
    check("stall_state", state, 1);
    check("stall_count", count, 1);
    retire(32'h80000180, 5'd0, 1'b0, 32'h1234, 1'b1);
    check("exc_post", state, 2);
    check("exc_count", count, 2);
    retire(32'h300, 5'd4, 1'b1, 32'h3, 1'b0);
    retire(32'h304, 5'd5, 1'b1, 32'h4, 1'b0);
    retire(32'h308, 5'd6, 1'b1, 32'h5, 1'b0);
    check("exc_done", state, 3);
    check("exc_count_done", count, 5);
    check("exc_trig_pos", trig_pos, 1);
    read(3'd1);
    check("exc_trig_rec", rd_rec, mk_rec(1'b1, 1'b0, 5'd0, 32'h1234, 32'h80000180));
    read(3'd4);
    check("exc_last_pc", rd_rec[PC_W-1:0], 32'h308);
    read(3'd5);
    check("bound_rd_err", rd_err, 1);
    check("bound_rd_rec", rd_rec, 0);
    check("bound_rd_valid", rd_valid, 1);

    // arm coincident with a matching PC: no capture, fresh ARMED.
    trig_exc_en = 1'b0; trig_pc_en = 1'b1; trig_pc = 32'h400;
    arm = 1'b1;
    retire(32'h400, 5'd1, 1'b1, 32'h1, 1'b0);
    arm = 1'b0;
    check("arm_trig_state", state, 1);
    check("arm_trig_count", count, 0);
    read(3'd0);
    check("armed_rd_err", rd_err, 1);

    // Reset in the middle of the post window.
    retire(32'h400, 5'd1, 1'b1, 32'h1, 1'b0);
    retire(32'h404, 5'd1, 1'b1, 32'h2, 1'b0);
    check("midpost_state", state, 2);
    check("midpost_count", count, 2);
    resetn = 1'b0; rd_en = 1'b1; rd_idx = 3'd0;
    tick();
    resetn = 1'b1; rd_en = 1'b0;
    check("rst_post_state", state, 0);
    check("rst_post_count", count, 0);
    check("rst_post_rd_valid", rd_valid, 0);
    retire(32'h408, 5'd1, 1'b1, 32'h3, 1'b0);
    check("rst_post_no_cap", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Synthesizable successor to the simulation-only pipeline monitor: records retired write-back events into a circular on-chip buffer, so post-mortem pipeline state is available in hardware.
- Sits beside the WB stage. Samples pc_wb, rw_wb, reg_din_wb, reg_we_wb and is_exception.
- Freezes a configurable pre/post window around a PC-match or exception trigger. The frozen window is then read out by index.
- Depth, post-trigger length and data widths are parameters.

Parameters:
- DEPTH, 16, number of records; power of 2, ≥4.
- AW, 4, log2(DEPTH).
- PC_W, 32, PC width.
- DATA_W, 32, write-back data width.
- POST_DEPTH, 4, records captured after the trigger record; must be < DEPTH. Checked at elaboration.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- wb_valid  in  1  an instruction retires in WB this cycle.
- stall_memwb  in  1  WB held; no capture this cycle.
- pc_wb  in  PC_W  retiring PC.
- rw_wb  in  5  destination register.
- reg_we_wb  in  1  register write enable.
- reg_din_wb  in  DATA_W  write-back data.
- is_exception  in  1  exception flagged for this instruction.
- arm  in  1  one-cycle pulse: clear buffer, enter ARMED.
- trig_pc_en  in  1  enable PC-match trigger.
- trig_pc  in  PC_W  trigger PC.
- trig_exc_en  in  1  enable exception trigger.
- rd_en  in  1  readout request.
- rd_idx  in  AW  record index; 0 = oldest.
- rd_valid  out  1  rd_rec valid.
- rd_err  out  1  request out of range or buffer not DONE.
- rd_rec  out  PC_W+DATA_W+7  record {is_exc, reg_we, rw[4:0], din, pc}.
- count  out  AW+1  valid records, saturating at DEPTH.
- trig_pos  out  AW  index (oldest = 0) of the trigger record.
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.

Behaviour:
- Reset (resetn=0 at clk edge): state IDLE, wr_ptr 0, count 0, post_cnt 0, trig_pos 0, rd_valid 0, rd_err 0, rd_rec 0. Storage array is not reset. Reset mid-capture aborts to IDLE.
- Capture cycle: cap = wb_valid & ~stall_memwb & (state==ARMED | state==POST).
  - On cap, write the record at wr_ptr.
  - wr_ptr increments mod DEPTH (wraps DEPTH-1→0).
  - count increments and saturates at DEPTH. On overflow the oldest record is overwritten.
- arm, any state: next state ARMED; wr_ptr, count and post_cnt cleared. No record is written that cycle even if cap would hold. arm has priority over trigger and over rd_en.
- IDLE: no capture. Leaves only on arm.
- ARMED:
  - trig = cap & ((trig_pc_en & pc_wb==trig_pc) | (trig_exc_en & is_exception)).
  - On trig, write the trigger record and latch trig_ptr = wr_ptr.
  - If POST_DEPTH==0 → DONE; else post_cnt ← POST_DEPTH → POST.
- POST: each cap writes a record and decrements post_cnt. The cap that brings post_cnt to 0 writes its record, then → DONE. Triggers are ignored in POST.
- DONE: no capture; contents frozen until arm or reset.
- trig_pos: (trig_ptr − oldest_ptr) mod DEPTH, where oldest_ptr = (wr_ptr − count) mod DEPTH. Updated every cycle from registers.
- Readout: 1-cycle latency. rd_en at cycle N → rd_valid=1 at N+1, for exactly one cycle per request. Back-to-back requests are allowed, one per cycle.
  - state==DONE and rd_idx < count: rd_rec = mem[(oldest_ptr + rd_idx) mod DEPTH], rd_err=0.
  - Otherwise: rd_rec = 0, rd_err=1.
  - rd_en with no request pending: rd_valid=0, rd_err=0, rd_rec holds its value.
- Buffer full with post window pending: wrap continues. Because POST_DEPTH < DEPTH, the trigger record always survives.

Test Plan (DEPTH=8, POST_DEPTH=3):
- Reset then idle traffic: 10 wb_valid cycles, no arm → state=0, count=0. rd_en idx 0 → rd_valid=1, rd_err=1, rd_rec=0.
- Basic window:
  - Stimulus: arm; trig_pc_en=1, trig_pc=0xBFC00010; retire PCs 0xBFC00000..0xBFC0001C step 4, reg_we=1, din=PC.
  - Response: trigger at the 5th record, DONE after 0xBFC0001C; count=8, trig_pos=4.
  - Readout: rd_idx 0 → pc 0xBFC00000; rd_idx 7 → 0xBFC0001C.
- Wrap: arm; 20 retires of PC 0x100+4k, trigger at k=15 → DONE after k=18. count=8, oldest pc=0x12C (k=11), trig_pos=4, rd_idx 7 → 0x148.
- Stall/exception:
  - Stimulus: trig_exc_en=1; stall_memwb=1 alongside wb_valid; then a retire with is_exception=1 at pc 0x80000180.
  - Response: stalled cycles are not captured. Trigger record has is_exc=1, and its index equals trig_pos.
- Boundary: rd_idx=count in DONE → rd_err=1. arm asserted in the same cycle as a matching PC → state ARMED, count=0.
- Reset mid-POST: resetn=0 for 1 cycle while post_cnt=2 → state IDLE, count=0, rd_valid=0 next cycle.
